// File: rtl/ahb_fifo_pkg.sv
// ahb_fifo_pkg: shared constants and helpers for the ahb_sync_fifo slice.
// Default geometry, depth computation and margin legality check.
package ahb_fifo_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 7;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic bit margins_ok(
    input int depth,
    input int af_margin,
    input int ae_margin
  );
    return (af_margin > 0) && (af_margin < depth) &&
           (ae_margin >= 0) && (ae_margin < depth);
  endfunction

endpackage

// File: rtl/ahb_fifo_ram.sv
// ahb_fifo_ram: DEPTH x DATA_W array, sync write, async read.
// Swap point for a vendor dual-port RAM.
module ahb_fifo_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic              wclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge wclk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd = mem[ra];

endmodule

// File: rtl/ahb_sync_fifo.sv
// ahb_sync_fifo: parametrised first-word-fall-through single-clock FIFO.
// Sticky overflow/underflow flags compiled in with AHB_FIFO_ERR_EN.
module ahb_sync_fifo
  import ahb_fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AF_MARGIN = 4,
  parameter int AE_MARGIN = 4
) (
  input  logic              clock,
  input  logic              reset,
`ifdef AHB_FIFO_ERR_EN
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow,
`endif
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = fifo_depth(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_C =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_LVL =
    (ADDR_W+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_W:0] AE_LVL =
    (ADDR_W+1)'(AE_MARGIN);

  if (!margins_ok(DEPTH, AF_MARGIN, AE_MARGIN))
  begin : g_bad_margin
    $error("ahb_sync_fifo: illegal AF/AE margin");
  end

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   cnt;
  logic              pop_ok;
  logic              push_ok;
  logic              wr_en;

  assign empty        = (cnt == '0);
  assign full         = (cnt == DEPTH_C);
  assign almost_full  = (cnt >= AF_LVL);
  assign almost_empty = (cnt <= AE_LVL);
  assign count        = cnt;

  // A full FIFO still takes a push when a pop frees the slot.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign wr_en   = push_ok & ~flush & ~reset;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  ahb_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .wclk (clock),
    .we   (wr_en),
    .wa   (wptr),
    .wd   (din),
    .ra   (rptr),
    .rd   (dout)
  );

`ifdef AHB_FIFO_ERR_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge clock) begin
    if (reset || err_clr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (push && !push_ok) ovf_q <= 1'b1;
      if (pop && empty)     unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_ahb_sync_fifo.sv
// tb_ahb_sync_fifo: directed plus random stimulus for ahb_sync_fifo,
// checked against a queue-based reference model.
module tb_ahb_sync_fifo;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFM   = 2;
  localparam int AEM   = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          push  = 1'b0;
  logic          pop   = 1'b0;
  logic [DW-1:0] din   = '0;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
`ifdef AHB_FIFO_ERR_EN
  logic          err_clr = 1'b0;
  logic          overflow;
  logic          underflow;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf = 0;
  bit            m_unf = 0;

  ahb_sync_fifo #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .AF_MARGIN (AFM),
    .AE_MARGIN (AEM)
  ) dut (
    .clock        (clock),
    .reset        (reset),
`ifdef AHB_FIFO_ERR_EN
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .flush        (flush),
    .push         (push),
    .pop          (pop),
    .din          (din),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
  );

  always #5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock: drive, let the model apply the accept rules, compare.
  task automatic step(
    input logic          p,
    input logic          o,
    input logic [DW-1:0] d,
    input logic          f,
    input logic          r,
    input logic          ec
  );
    int  sz;
    bit  pok;
    bit  wok;
    push  = p;
    pop   = o;
    din   = d;
    flush = f;
    reset = r;
`ifdef AHB_FIFO_ERR_EN
    err_clr = ec;
`endif
    sz  = q.size();
    pok = o && (sz > 0);
    wok = p && ((sz < DEPTH) || pok);
    if (r || ec) begin
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (p && !wok) m_ovf = 1;
      if (o && sz == 0) m_unf = 1;
    end
    @(posedge clock);
    if (r || f) begin
      q.delete();
    end else begin
      if (pok) void'(q.pop_front());
      if (wok) q.push_back(d);
    end
    #1;
    sz = q.size();
    chk("count", 64'(count), 64'(sz));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("full", 64'(full), 64'(sz == DEPTH));
    chk("afull", 64'(almost_full),
        64'(sz >= DEPTH - AFM));
    chk("aempty", 64'(almost_empty),
        64'(sz <= AEM));
    if (sz > 0) chk("dout", 64'(dout), 64'(q[0]));
`ifdef AHB_FIFO_ERR_EN
    chk("ovf", 64'(overflow), 64'(m_ovf));
    chk("unf", 64'(underflow), 64'(m_unf));
`endif
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    // reset values
    step(0, 0, '0, 0, 1, 0);
    chk("rst_cnt", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_ae", 64'(almost_empty), 64'd1);
    chk("rst_af", 64'(almost_full), 64'd0);
    idle();

    // basic FWFT ordering
    for (int i = 0; i < 4; i++)
      step(1, 0, DW'(8'h11 + i), 0, 0, 0);
    chk("b_cnt", 64'(count), 64'd4);
    chk("b_dout", 64'(dout), 64'h11);
    chk("b_empty", 64'(empty), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, '0, 0, 0, 0);
      chk("b_pop", 64'(dout), 64'(8'h12 + i));
    end
    step(0, 1, '0, 0, 0, 0);
    chk("b_empty2", 64'(empty), 64'd1);

    // fill to full, then overflow
    for (int i = 0; i < 8; i++) begin
      step(1, 0, DW'(32'h100 + i), 0, 0, 0);
      if (i == 4) chk("af5", 64'(almost_full), 64'd0);
      if (i == 5) chk("af6", 64'(almost_full), 64'd1);
      if (i == 6) chk("full7", 64'(full), 64'd0);
    end
    chk("full8", 64'(full), 64'd1);
    step(1, 0, 32'hDEAD, 0, 0, 0);
    chk("ovf_cnt", 64'(count), 64'd8);
`ifdef AHB_FIFO_ERR_EN
    chk("ovf_set", 64'(overflow), 64'd1);
`endif

    // push+pop while full
    step(1, 1, 32'hAA, 0, 0, 0);
    chk("pp_cnt", 64'(count), 64'd8);
    chk("pp_full", 64'(full), 64'd1);
    for (int i = 0; i < 7; i++) step(0, 1, '0, 0, 0, 0);
    chk("pp_head", 64'(dout), 64'hAA);
    step(0, 1, '0, 0, 0, 0);

    // push+pop while empty
    step(1, 1, 32'h55, 0, 0, 0);
    chk("pe_cnt", 64'(count), 64'd1);
    chk("pe_dout", 64'(dout), 64'h55);
`ifdef AHB_FIFO_ERR_EN
    chk("unf_set", 64'(underflow), 64'd1);
    step(0, 0, '0, 0, 0, 1);
    chk("unf_clr", 64'(underflow), 64'd0);
`endif

    // wrap-around, occupancy held in 3..5
    step(1, 0, 32'h56, 0, 0, 0);
    step(1, 0, 32'h57, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      logic p;
      logic o;
      p = 1'($urandom);
      o = 1'($urandom);
      if (q.size() <= 3) p = 1;
      if (q.size() >= 5) o = 1;
      if (q.size() <= 3) o = (p && o) ? 1'b1 : 1'b0;
      if (q.size() >= 5) p = (p && o) ? 1'b1 : 1'b0;
      step(p, o, DW'($urandom), 0, 0, 0);
      chk("wrap_rng", 64'(q.size() >= 3 && q.size() <= 5),
          64'(count >= 3 && count <= 5));
    end

    // flush with a same-cycle push
    while (q.size() < 5) step(1, 0, DW'($urandom), 0, 0, 0);
    while (q.size() > 5) step(0, 1, '0, 0, 0, 0);
    step(1, 0, 32'h77, 1, 0, 0);
    chk("fl_cnt", 64'(count), 64'd0);
    chk("fl_empty", 64'(empty), 64'd1);
    idle();

    // random soak
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55),
           1'($urandom_range(0, 99) < 50),
           DW'($urandom),
           1'($urandom_range(0, 99) < 3),
           1'($urandom_range(0, 199) < 1),
           1'($urandom_range(0, 99) < 5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
